// File: rtl/spi_xfer_pkg.sv
// Shared definitions for the SPI-to-BRAM transfer controller.
//
// Contents:
//   CMD_WRITE / CMD_READ / CMD_STATUS : command byte values
//   state_t                           : controller state encoding (3 bits)
//   ERR_OVF / ERR_ZERO / ERR_ABORT    : bit positions in the sticky error vector
package spi_xfer_pkg;

  localparam logic [7:0] CMD_WRITE  = 8'h01;
  localparam logic [7:0] CMD_READ   = 8'h02;
  localparam logic [7:0] CMD_STATUS = 8'h03;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR  = 3'd1,
    CALC = 3'd2,
    WR   = 3'd3,
    RD   = 3'd4
  } state_t;

  localparam int ERR_OVF   = 0;
  localparam int ERR_ZERO  = 1;
  localparam int ERR_ABORT = 2;

endpackage

// File: rtl/spi_bram_xfer_ctrl.sv
// SPI-to-BRAM image transfer controller.
//
// Decodes a command byte from the SPI slave byte interface, collects a
// 4-byte height/width header, and then either writes the frame into a
// single-port BRAM or streams it back out of the BRAM. Chip-select going
// high mid-frame aborts the transfer. Errors are sticky until a STATUS
// command reads them out or reset is applied.
//
// Ports:
//   clk, rst       : system clock, asynchronous active-low reset
//   cs_n           : SPI chip select (clk-synchronous), high = frame boundary
//   byte_valid     : one-cycle strobe, byte_in holds a complete byte
//   byte_in        : received SPI byte
//   byte_out       : byte presented for the next SPI transfer
//   bram_addr/we/wdata : BRAM write/read port
//   bram_rdata     : BRAM read data, one cycle after the address
//   busy           : controller is not idle
//   frame_done     : one-cycle pulse after the last data byte
//   state          : current state encoding
//   err            : sticky flags {abort, zero size, overflow}
module spi_bram_xfer_ctrl
  import spi_xfer_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 15,
  parameter int MEM_DEPTH = 19200,
  parameter int DIM_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs_n,
  input  logic              byte_valid,
  input  logic [DATA_W-1:0] byte_in,
  output logic [DATA_W-1:0] byte_out,
  output logic [ADDR_W-1:0] bram_addr,
  output logic              bram_we,
  output logic [DATA_W-1:0] bram_wdata,
  input  logic [DATA_W-1:0] bram_rdata,
  output logic              busy,
  output logic              frame_done,
  output logic [2:0]        state,
  output logic [2:0]        err
);

  localparam int IDX_W = 2 * DIM_W;
  localparam logic [IDX_W-1:0] DEPTH_L = IDX_W'(MEM_DEPTH);
  localparam logic [IDX_W-1:0] ONE_L   = IDX_W'(1);

  state_t              state_q, nxt_state;
  logic                write_mode_q, nxt_mode;
  logic [31:0]         hdr_q, nxt_hdr;
  logic [1:0]          hdr_cnt_q, nxt_cnt;
  logic [IDX_W-1:0]    index_q, nxt_idx;
  logic [IDX_W-1:0]    total_q, nxt_total;
  logic                issue_q, nxt_issue;
  logic                issue_zero_q, nxt_issue_zero;
  logic                cap_q, nxt_cap;
  logic                cap_zero_q, nxt_cap_zero;
  logic                clear_ctx;

  logic [DATA_W-1:0]   nxt_byte_out;
  logic [ADDR_W-1:0]   nxt_addr;
  logic                nxt_we;
  logic [DATA_W-1:0]   nxt_wdata;
  logic                nxt_done;
  logic [2:0]          nxt_err;

  logic [DIM_W-1:0]    height;
  logic [DIM_W-1:0]    width;
  logic [IDX_W-1:0]    product;
  logic [IDX_W-1:0]    idx_inc;
  logic                last_byte;
  logic [DATA_W-1:0]   status_byte;

  // The header shift register holds height in the upper half and width in
  // the lower half once all four bytes are in; the product is only
  // consumed during CALC.
  assign height    = DIM_W'(hdr_q[31:16]);
  assign width     = DIM_W'(hdr_q[15:0]);
  assign product   = IDX_W'(height) * IDX_W'(width);
  assign idx_inc   = index_q + ONE_L;
  assign last_byte = (index_q == total_q - ONE_L);
  assign state     = state_q;

  // STATUS reply: error flags in the top of the low byte, state in the
  // bottom, zero-extended when the SPI byte is wider than eight bits.
  always_comb begin
    status_byte      = '0;
    status_byte[7:0] = {err, 2'b00, state_q};
  end

  // Next-state and next-output logic. Every output is registered, so this
  // block computes the value each register takes on the next clock. The
  // read pipeline is two stages: an address issued in one cycle returns
  // data from the BRAM one cycle later, which is then captured into
  // byte_out. Abort on chip select has priority over any byte in flight.
  always_comb begin
    nxt_state      = state_q;
    nxt_byte_out   = byte_out;
    nxt_addr       = bram_addr;
    nxt_we         = 1'b0;
    nxt_wdata      = bram_wdata;
    nxt_done       = 1'b0;
    nxt_err        = err;
    nxt_mode       = write_mode_q;
    nxt_hdr        = hdr_q;
    nxt_cnt        = hdr_cnt_q;
    nxt_idx        = index_q;
    nxt_total      = total_q;
    nxt_issue      = 1'b0;
    nxt_issue_zero = 1'b0;
    nxt_cap        = issue_q;
    nxt_cap_zero   = issue_zero_q;
    clear_ctx      = 1'b0;

    if (cap_q) begin
      nxt_byte_out = cap_zero_q ? '0 : bram_rdata;
    end

    if (cs_n && (state_q != IDLE)) begin
      nxt_state          = IDLE;
      nxt_err[ERR_ABORT] = 1'b1;
      nxt_cap            = 1'b0;
      nxt_cap_zero       = 1'b0;
      clear_ctx          = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (byte_valid && !cs_n) begin
            if (byte_in == DATA_W'(CMD_WRITE)) begin
              nxt_mode  = 1'b1;
              nxt_state = HDR;
            end else if (byte_in == DATA_W'(CMD_READ)) begin
              nxt_mode  = 1'b0;
              nxt_state = HDR;
            end else if (byte_in == DATA_W'(CMD_STATUS)) begin
              nxt_byte_out = status_byte;
              nxt_err      = '0;
            end
          end
        end

        HDR: begin
          if (byte_valid) begin
            nxt_hdr = {hdr_q[23:0], byte_in[7:0]};
            nxt_cnt = hdr_cnt_q + 2'd1;
            if (hdr_cnt_q == 2'd3) begin
              nxt_state = CALC;
            end
          end
        end

        CALC: begin
          if (product == '0) begin
            nxt_err[ERR_ZERO] = 1'b1;
            nxt_state         = IDLE;
            clear_ctx         = 1'b1;
          end else begin
            if (product > DEPTH_L) begin
              nxt_err[ERR_OVF] = 1'b1;
            end
            nxt_total = product;
            nxt_idx   = '0;
            if (write_mode_q) begin
              nxt_state = WR;
            end else begin
              nxt_state = RD;
              nxt_addr  = '0;
              nxt_issue = 1'b1;
            end
          end
        end

        WR: begin
          if (byte_valid) begin
            nxt_byte_out = byte_in;
            if (index_q < DEPTH_L) begin
              nxt_we    = 1'b1;
              nxt_addr  = index_q[ADDR_W-1:0];
              nxt_wdata = byte_in;
            end
            if (last_byte) begin
              nxt_done  = 1'b1;
              nxt_state = IDLE;
              clear_ctx = 1'b1;
            end else begin
              nxt_idx = idx_inc;
            end
          end
        end

        RD: begin
          if (byte_valid) begin
            if (last_byte) begin
              nxt_done  = 1'b1;
              nxt_state = IDLE;
              clear_ctx = 1'b1;
            end else begin
              nxt_idx   = idx_inc;
              nxt_issue = 1'b1;
              if (idx_inc < DEPTH_L) begin
                nxt_addr = idx_inc[ADDR_W-1:0];
              end else begin
                nxt_issue_zero = 1'b1;
              end
            end
          end
        end

        default: begin
          nxt_state = IDLE;
          clear_ctx = 1'b1;
        end
      endcase
    end

    if (clear_ctx) begin
      nxt_idx   = '0;
      nxt_hdr   = '0;
      nxt_cnt   = '0;
      nxt_total = '0;
    end
  end

  // State and output registers. Reset is asynchronous so that pulling it
  // low mid-frame drops bram_we before the next clock can complete a write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      write_mode_q <= 1'b0;
      hdr_q        <= '0;
      hdr_cnt_q    <= '0;
      index_q      <= '0;
      total_q      <= '0;
      issue_q      <= 1'b0;
      issue_zero_q <= 1'b0;
      cap_q        <= 1'b0;
      cap_zero_q   <= 1'b0;
      byte_out     <= '0;
      bram_addr    <= '0;
      bram_we      <= 1'b0;
      bram_wdata   <= '0;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
      err          <= '0;
    end else begin
      state_q      <= nxt_state;
      write_mode_q <= nxt_mode;
      hdr_q        <= nxt_hdr;
      hdr_cnt_q    <= nxt_cnt;
      index_q      <= nxt_idx;
      total_q      <= nxt_total;
      issue_q      <= nxt_issue;
      issue_zero_q <= nxt_issue_zero;
      cap_q        <= nxt_cap;
      cap_zero_q   <= nxt_cap_zero;
      byte_out     <= nxt_byte_out;
      bram_addr    <= nxt_addr;
      bram_we      <= nxt_we;
      bram_wdata   <= nxt_wdata;
      busy         <= (nxt_state != IDLE);
      frame_done   <= nxt_done;
      err          <= nxt_err;
    end
  end

endmodule
